// File: rtl/klotski_pkg.sv
// Shared types and cell arithmetic for the klotski move executor.
// A cell is {row[3:2], col[1:0]}; both coordinates are always in the range 0..3.
package klotski_pkg;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } cell_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SEEK_X,
        S_SEEK_Y,
        S_GRAB,
        S_CARRY,
        S_RELEASE,
        S_DONE
    } exec_state_t;

    // |a - b| for one 2-bit coordinate, computed through a 3-bit signed difference.
    function automatic logic [1:0] coord_dist(input logic [1:0] a, input logic [1:0] b);
        logic signed [2:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 2'(-d) : 2'(d);
    endfunction

    function automatic logic [2:0] cell_dist(input cell_t a, input cell_t b);
        return {1'b0, coord_dist(a.row, b.row)} + {1'b0, coord_dist(a.col, b.col)};
    endfunction

endpackage

// File: rtl/klotski_step_gen.sv
// Step pulse generator: after a start strobe, emits i_steps pulses, each STEP_PERIOD
// cycles long and high for the first STEP_HIGH cycles; o_done marks the final cycle.
module klotski_step_gen #(
    parameter int STEP_PERIOD = 5000,
    parameter int STEP_HIGH   = 100,
    parameter int CNT_W       = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_steps,
    output logic             o_step,
    output logic             o_step_end,
    output logic             o_done
);

    localparam int PER_W = $clog2(STEP_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);

    logic             active;
    logic [PER_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] steps_left;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active     <= 1'b0;
            cyc_cnt    <= '0;
            steps_left <= '0;
        end else if (i_start) begin
            active     <= (i_steps != '0);
            cyc_cnt    <= '0;
            steps_left <= i_steps;
        end else if (active) begin
            if (cyc_cnt == PER_LAST) begin
                cyc_cnt    <= '0;
                steps_left <= steps_left - 1'b1;
                if (steps_left == CNT_W'(1))
                    active <= 1'b0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign o_step     = active && (cyc_cnt < PER_W'(STEP_HIGH));
    assign o_step_end = active && (cyc_cnt == PER_LAST);
    assign o_done     = o_step_end && (steps_left == CNT_W'(1));

endmodule

// File: rtl/klotski_move_exec.sv
// Move executor: seeks the gantry to the tile, grabs it, carries it one cell into the blank.
// Build option KLOTSKI_SETTLE_EN: GRAB and RELEASE dwell SETTLE_CYCLES instead of one cycle.
module klotski_move_exec #(
    parameter int STEP_PERIOD    = 5000,
    parameter int STEP_HIGH      = 100,
    parameter int STEPS_PER_CELL = 200,
    parameter int SETTLE_CYCLES  = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_start_block,
    input  logic [3:0] i_end_block,
    output logic       o_continue,
    output logic       o_error,
    output logic       o_busy,
    output logic       o_step_x,
    output logic       o_step_y,
    output logic       o_dir_x,
    output logic       o_dir_y,
    output logic       o_magnet,
    output logic [3:0] o_head_pos
);

    import klotski_pkg::*;

    localparam int CNT_W  = $clog2(3 * STEPS_PER_CELL + 1);
    localparam int CELL_W = $clog2(STEPS_PER_CELL + 1);

    exec_state_t       state, next_state;
    cell_t             start_q, end_q, head;
    logic              err_q;
    logic              dir_x_q, dir_y_q, dir_x, dir_y;
    logic [CELL_W-1:0] cell_cnt;
    logic              seg_start;
    logic [1:0]        seg_cells;
    logic [CNT_W-1:0]  seg_steps;
    logic              sg_step, sg_step_end, sg_done;
    logic              cell_tick;
    logic              dwell_done;
    logic [1:0]        n_x, n_y;
    logic              carry_x;

    assign n_x       = coord_dist(start_q.col, head.col);
    assign n_y       = coord_dist(start_q.row, head.row);
    assign carry_x   = (start_q.row == end_q.row);
    assign seg_steps = CNT_W'(seg_cells) * CNT_W'(STEPS_PER_CELL);
    assign cell_tick = sg_step_end && (cell_cnt == CELL_W'(STEPS_PER_CELL - 1));

`ifdef KLOTSKI_SETTLE_EN
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    logic [SET_W-1:0] settle_cnt;

    assign dwell_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            settle_cnt <= '0;
        else if ((state == S_GRAB || state == S_RELEASE) && !dwell_done)
            settle_cnt <= settle_cnt + 1'b1;
        else
            settle_cnt <= '0;
    end
`else
    assign dwell_done = 1'b1;
`endif

    // Segment starts are raised in the last cycle of the preceding state, so the first
    // step pulse lands on the first cycle of the segment and dir leads it by one cycle.
    // NOTE: every always_comb output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        next_state = state;
        seg_start  = 1'b0;
        seg_cells  = 2'd0;
        dir_x      = dir_x_q;
        dir_y      = dir_y_q;
        case (state)
            S_IDLE: if (i_en) next_state = S_CHECK;
            S_CHECK: begin
                if (cell_dist(start_q, end_q) != 3'd1) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_SEEK_X;
                    if (n_x != 2'd0) begin
                        seg_start = 1'b1;
                        seg_cells = n_x;
                        dir_x     = (start_q.col > head.col);
                    end
                end
            end
            S_SEEK_X: begin
                if (sg_done || n_x == 2'd0) begin
                    next_state = S_SEEK_Y;
                    if (n_y != 2'd0) begin
                        seg_start = 1'b1;
                        seg_cells = n_y;
                        dir_y     = (start_q.row > head.row);
                    end
                end
            end
            S_SEEK_Y: if (sg_done || n_y == 2'd0) next_state = S_GRAB;
            S_GRAB: begin
                if (dwell_done) begin
                    next_state = S_CARRY;
                    seg_start  = 1'b1;
                    seg_cells  = 2'd1;
                    if (carry_x) dir_x = (end_q.col > start_q.col);
                    else         dir_y = (end_q.row > start_q.row);
                end
            end
            S_CARRY:   if (sg_done) next_state = S_RELEASE;
            S_RELEASE: if (dwell_done) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            head     <= '0;
            err_q    <= 1'b0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            cell_cnt <= '0;
        end else begin
            state   <= next_state;
            dir_x_q <= dir_x;
            dir_y_q <= dir_y;
            if (state == S_IDLE && i_en) begin
                start_q <= cell_t'(i_start_block);
                end_q   <= cell_t'(i_end_block);
            end
            if (state == S_CHECK)
                err_q <= (cell_dist(start_q, end_q) != 3'd1);
            if (seg_start)
                cell_cnt <= '0;
            else if (cell_tick)
                cell_cnt <= '0;
            else if (sg_step_end)
                cell_cnt <= cell_cnt + 1'b1;
            if (cell_tick) begin
                if (state == S_SEEK_X || (state == S_CARRY && carry_x))
                    head.col <= dir_x_q ? head.col + 2'd1 : head.col - 2'd1;
                else
                    head.row <= dir_y_q ? head.row + 2'd1 : head.row - 2'd1;
            end
        end
    end

    klotski_step_gen #(
        .STEP_PERIOD (STEP_PERIOD),
        .STEP_HIGH   (STEP_HIGH),
        .CNT_W       (CNT_W)
    ) u_step_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (seg_start),
        .i_steps    (seg_steps),
        .o_step     (sg_step),
        .o_step_end (sg_step_end),
        .o_done     (sg_done)
    );

    assign o_step_x   = sg_step && (state == S_SEEK_X || (state == S_CARRY && carry_x));
    assign o_step_y   = sg_step && (state == S_SEEK_Y || (state == S_CARRY && !carry_x));
    assign o_dir_x    = dir_x;
    assign o_dir_y    = dir_y;
    assign o_magnet   = (state == S_GRAB) || (state == S_CARRY);
    assign o_busy     = (state != S_IDLE);
    assign o_continue = (state == S_DONE);
    assign o_error    = (state == S_DONE) && err_q;
    assign o_head_pos = head;

endmodule

// File: tb/tb_klotski_move_exec.sv
// Directed bench for klotski_move_exec with small timing parameters.
// Cycle k is the clock period that ends at edge k; i_en is high in cycle 0.
module tb_klotski_move_exec;

    localparam int SP  = 4;
    localparam int SH  = 1;
    localparam int SPC = 2;
    localparam int SC  = 3;
`ifdef KLOTSKI_SETTLE_EN
    localparam int DWELL = SC;
`else
    localparam int DWELL = 1;
`endif
    localparam int EXTRA = 2 * (DWELL - 1);
    localparam int CARRY_CYC = SPC * SP;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic [3:0] i_start_block = 4'h0;
    logic [3:0] i_end_block = 4'h0;
    logic       o_continue, o_error, o_busy, o_step_x, o_step_y;
    logic       o_dir_x, o_dir_y, o_magnet;
    logic [3:0] o_head_pos;

    int n_checks = 0;
    int n_fails  = 0;

    klotski_move_exec #(
        .STEP_PERIOD    (SP),
        .STEP_HIGH      (SH),
        .STEPS_PER_CELL (SPC),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_start_block (i_start_block),
        .i_end_block   (i_end_block),
        .o_continue    (o_continue),
        .o_error       (o_error),
        .o_busy        (o_busy),
        .o_step_x      (o_step_x),
        .o_step_y      (o_step_y),
        .o_dir_x       (o_dir_x),
        .o_dir_y       (o_dir_y),
        .o_magnet      (o_magnet),
        .o_head_pos    (o_head_pos)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one request and watches every cycle up to exp_cont+4.
    // exp_sdir / exp_cdir of -1 skip the seek-x / carry direction checks.
    task automatic run_move(input string tag, input logic [3:0] s, input logic [3:0] e,
                            input int exp_cont, input logic exp_err, input logic [3:0] exp_head,
                            input int exp_xs, input int exp_ys, input int exp_pre,
                            input int exp_sdir, input int exp_cdir,
                            input int en_p1, input int en_p2);
        int   cont_cyc, n_cont, n_err, err_at_cont, xs, ys, both, mag, pre, sdir, cdir;
        int   busy1, busy_after;
        logic seen;
        cont_cyc = -1; n_cont = 0; n_err = 0; err_at_cont = -1; xs = 0; ys = 0; both = 0;
        mag = 0; pre = 0; sdir = -1; cdir = -1; busy1 = -1; busy_after = -1; seen = 1'b0;
        i_start_block = s;
        i_end_block   = e;
        i_en          = 1'b1;
        for (int c = 1; c <= exp_cont + 4; c++) begin
            tick();
            i_en = (c == en_p1) || (c == en_p2);
            if (c == 1) busy1 = int'(o_busy);
            if (o_continue) begin
                n_cont++;
                if (cont_cyc < 0) begin
                    cont_cyc    = c;
                    err_at_cont = int'(o_error);
                end
            end
            if (o_error) n_err++;
            if (cont_cyc >= 0 && c == cont_cyc + 1) busy_after = int'(o_busy);
            if (o_step_x) xs++;
            if (o_step_y) ys++;
            if (o_step_x && o_step_y) both++;
            if (o_step_x && !o_magnet && sdir < 0) sdir = int'(o_dir_x);
            if (o_magnet) begin
                mag++;
                if (!seen) begin
                    if (o_step_x || o_step_y) begin
                        seen = 1'b1;
                        cdir = o_step_x ? int'(o_dir_x) : int'(o_dir_y);
                    end else begin
                        pre++;
                    end
                end
            end
        end
        i_en = 1'b0;
        check({tag, ".cont_cycle"}, cont_cyc, exp_cont);
        check({tag, ".cont_count"}, n_cont, 1);
        check({tag, ".err_at_cont"}, err_at_cont, int'(exp_err));
        check({tag, ".err_count"}, n_err, int'(exp_err));
        check({tag, ".busy_c1"}, busy1, 1);
        check({tag, ".busy_after"}, busy_after, 0);
        check({tag, ".step_x"}, xs, exp_xs);
        check({tag, ".step_y"}, ys, exp_ys);
        check({tag, ".step_both"}, both, 0);
        check({tag, ".mag_pre"}, pre, exp_pre);
        check({tag, ".mag_total"}, mag, exp_err ? 0 : exp_pre + CARRY_CYC);
        check({tag, ".head"}, o_head_pos, exp_head);
        if (exp_sdir >= 0) check({tag, ".seek_dir_x"}, sdir, exp_sdir);
        if (exp_cdir >= 0) check({tag, ".carry_dir"}, cdir, exp_cdir);
    endtask

    initial begin
        int r;
        tick(); tick(); tick();
        check("reset.outputs",
              {o_continue, o_error, o_busy, o_step_x, o_step_y, o_dir_x, o_dir_y, o_magnet}, 0);
        check("reset.head", o_head_pos, 4'h0);
        i_rst = 1'b0;
        tick();

        // Seek x 1 cell right, zero-length seek y, carry 1 cell left.
        run_move("s1", 4'h1, 4'h0, 21 + EXTRA, 1'b0, 4'h0, 4, 0, DWELL, 1, 0, 0, 0);
        // Seek x 1, seek y 1, carry right.
        run_move("s2", 4'h5, 4'h6, 28 + EXTRA, 1'b0, 4'h6, 4, 2, DWELL, 1, 1, 0, 0);
        // Non-adjacent and identical cells are rejected without motion.
        run_move("s3_far", 4'h0, 4'h5, 2, 1'b1, 4'h6, 0, 0, 0, -1, -1, 0, 0);
        run_move("s3_same", 4'h6, 4'h6, 2, 1'b1, 4'h6, 0, 0, 0, -1, -1, 0, 0);
        // Requests during CARRY (cycle 14) and DONE (cycle 21) must be ignored.
        run_move("s4", 4'h7, 4'h6, 21 + EXTRA, 1'b0, 4'h6, 4, 0, DWELL, 1, 0,
                 14 + (DWELL - 1), 21 + EXTRA);

        // Reset in the middle of a y carry from 0x2 to 0x6.
        r = 15 + (DWELL - 1);
        i_start_block = 4'h2;
        i_end_block   = 4'h6;
        i_en          = 1'b1;
        for (int c = 1; c <= r; c++) begin
            tick();
            i_en = 1'b0;
        end
        check("s5.magnet_before", o_magnet, 1'b1);
        check("s5.head_before", o_head_pos, 4'h2);
        i_rst = 1'b1;
        tick();
        check("s5.magnet_after", o_magnet, 1'b0);
        check("s5.busy_after", o_busy, 1'b0);
        check("s5.head_after", o_head_pos, 4'h0);
        i_rst = 1'b0;
        tick();

        // From home: zero-length seek x, seek y down 1, carry up.
        run_move("s6", 4'h4, 4'h0, 21 + EXTRA, 1'b0, 4'h0, 0, 4, DWELL, -1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
